// File: rtl/svnet_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : svnet_pipe_ctrl
// Description : Valid/ready sequencer for a chain of DEPTH enable-gated
//               pipeline registers. It produces the per-stage load enables,
//               tracks which stages hold valid data, collapses bubbles and
//               propagates downstream backpressure back to the producer.
//               Optional performance counters (stall_cnt, bubble_cnt) are
//               built when SVNET_PIPE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module svnet_pipe_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] stage_en,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] occupancy
`ifdef SVNET_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    // Reject unsupported depths at elaboration time.
    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
        $error("svnet_pipe_ctrl: DEPTH must be in the range 1..64");
    end

    logic [DEPTH-1:0] r_valid;
    logic [CNT_W-1:0] r_occ;
    logic [DEPTH-1:0] w_en;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CNT_W:0]   w_occ_ext;

    // Enable chain from the output back to the input: a stage loads when it is
    // empty or when the stage after it loads. Built with a running OR so each
    // bit depends only on valid flags and out_ready, never on other enable bits.
    always_comb begin : p_en_chain
        logic acc;
        acc  = out_ready;
        w_en = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc     = acc | ~r_valid[i];
            w_en[i] = acc;
        end
    end

    // Flush freezes every stage for its cycle so no handshake completes.
    assign stage_en    = flush ? '0 : w_en;
    assign in_ready    = ~flush & w_en[0];
    assign out_valid   = r_valid[DEPTH-1];
    assign stage_valid = r_valid;
    assign occupancy   = r_occ;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign w_occ_ext  = {1'b0, r_occ} + (CNT_W + 1)'(w_in_xfer) - (CNT_W + 1)'(w_out_xfer);

    // Valid flags advance through every enabled stage; stalled stages hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            if (w_en[0]) begin
                r_valid[0] <= in_valid;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_en[i]) begin
                    r_valid[i] <= r_valid[i-1];
                end
            end
        end
    end

    // Occupancy tracks input minus output transfers; the extra top bit would
    // only flag an underflow, which clamps to zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_occ_ext[CNT_W]) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_ext[CNT_W-1:0];
        end
    end

`ifdef SVNET_PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating counters of backpressure stalls and empty-output cycles with
    // data still in flight; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !flush && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((r_occ != '0) && !out_valid && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_svnet_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_svnet_pipe_ctrl
// Description : Self-checking bench for svnet_pipe_ctrl. A DEPTH=3 and a
//               DEPTH=4 instance share one stimulus stream; a word-position
//               model predicts every output each cycle, and directed literal
//               checks pin the model. Perf counters (DEPTH=2 instance) are
//               exercised when SVNET_PIPE_CTRL_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_svnet_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       check_en;

    logic       ir3, ov3, ir4, ov4;
    logic [2:0] en3, sv3;
    logic [1:0] oc3;
    logic [3:0] en4, sv4;
    logic [2:0] oc4;

    int checks = 0;
    int errors = 0;

`ifdef SVNET_PIPE_CTRL_PERF_EN
    logic [31:0] st3, bc3, st4, bc4, st2, bc2;
    logic        ir2, ov2;
    logic [1:0]  en2, sv2, oc2;
`endif

    svnet_pipe_ctrl #(.DEPTH(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .out_valid(ov3), .out_ready(out_ready), .stage_en(en3), .stage_valid(sv3),
        .occupancy(oc3)
`ifdef SVNET_PIPE_CTRL_PERF_EN
        , .stall_cnt(st3), .bubble_cnt(bc3)
`endif
    );

    svnet_pipe_ctrl #(.DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
        .out_valid(ov4), .out_ready(out_ready), .stage_en(en4), .stage_valid(sv4),
        .occupancy(oc4)
`ifdef SVNET_PIPE_CTRL_PERF_EN
        , .stall_cnt(st4), .bubble_cnt(bc4)
`endif
    );

`ifdef SVNET_PIPE_CTRL_PERF_EN
    svnet_pipe_ctrl #(.DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .out_valid(ov2), .out_ready(out_ready), .stage_en(en2), .stage_valid(sv2),
        .occupancy(oc2), .stall_cnt(st2), .bubble_cnt(bc2)
    );
`endif

    always #10 clk = ~clk;

    // External datapath registers loaded by stage_en, carrying word ids.
    logic [7:0] dp3[3];
    logic [7:0] dp4[4];
    always @(posedge clk) begin
        if (en3[0]) dp3[0] <= in_data;
        for (int i = 1; i < 3; i++) if (en3[i]) dp3[i] <= dp3[i-1];
        if (en4[0]) dp4[0] <= in_data;
        for (int i = 1; i < 4; i++) if (en4[i]) dp4[i] <= dp4[i-1];
    end

    // Model: list of in-flight words (oldest first) with stage position and id.
    int mpos[2][8];
    int mid[2][8];
    int mcnt[2] = '{0, 0};

    function automatic int dep(int k);
        return (k == 0) ? 3 : 4;
    endfunction

    // A word moves if the next position is free or the word ahead moves;
    // the oldest word leaves from the last stage only when out_ready.
    function automatic logic [7:0] exp_en(int k);
        logic [7:0] en;
        int         d;
        bit         prev;
        d    = dep(k);
        en   = 8'((1 << d) - 1);
        prev = 1'b0;
        if (flush) return 8'h00;
        for (int j = 0; j < mcnt[k]; j++) begin
            int p;
            bit mv;
            p = mpos[k][j];
            if (j == 0) mv = (p < d - 1) || out_ready;
            else        mv = (p + 1 < mpos[k][j-1]) || prev;
            en[p] = mv;
            prev  = mv;
        end
        return en;
    endfunction

    task automatic model_step(int k);
        logic [7:0] en;
        int         d, n;
        int         np[8];
        int         nid[8];
        d = dep(k);
        n = 0;
        if (flush) begin
            mcnt[k] = 0;
            return;
        end
        en = exp_en(k);
        for (int j = 0; j < mcnt[k]; j++) begin
            int p;
            p = mpos[k][j];
            if (en[p]) begin
                if (p != d - 1) begin
                    np[n] = p + 1; nid[n] = mid[k][j]; n++;
                end
            end else begin
                np[n] = p; nid[n] = mid[k][j]; n++;
            end
        end
        if (en[0] && in_valid) begin
            np[n] = 0; nid[n] = int'(in_data); n++;
        end
        for (int j = 0; j < n; j++) begin
            mpos[k][j] = np[j];
            mid[k][j]  = nid[j];
        end
        mcnt[k] = n;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic ir, input logic ov,
                            input logic [7:0] en, input logic [7:0] sv,
                            input logic [31:0] occ, input logic [7:0] word);
        logic [7:0] een, esv;
        logic       eov;
        een = exp_en(k);
        esv = 8'h00;
        for (int j = 0; j < mcnt[k]; j++) esv[mpos[k][j]] = 1'b1;
        eov = (mcnt[k] > 0) && (mpos[k][0] == dep(k) - 1);
        chk($sformatf("d%0d_in_ready", dep(k)), 32'(ir), 32'(een[0]));
        chk($sformatf("d%0d_stage_en", dep(k)), 32'(en), 32'(een));
        chk($sformatf("d%0d_stage_valid", dep(k)), 32'(sv), 32'(esv));
        chk($sformatf("d%0d_out_valid", dep(k)), 32'(ov), 32'(eov));
        chk($sformatf("d%0d_occupancy", dep(k)), occ, 32'(mcnt[k]));
        if (eov) chk($sformatf("d%0d_out_word", dep(k)), 32'(word), 32'(mid[k][0]));
    endtask

    // Compare process: all outputs against the model once per cycle.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            cmp_inst(0, ir3, ov3, {5'b0, en3}, {5'b0, sv3}, 32'(oc3), dp3[2]);
            cmp_inst(1, ir4, ov4, {4'b0, en4}, {4'b0, sv4}, 32'(oc4), dp4[3]);
            checks++;
            assert ($countones(sv3) == int'(oc3) && $countones(sv4) == int'(oc4))
            else begin
                errors++;
                $display("FAIL occ_popcount at %0t: occ %0d/%0d, valid %b/%b", $time, oc3, oc4, sv3, sv4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int acc;
        bit took;
        clk = 0; rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = 0; check_en = 0;

        // Reset state held while rst=1.
        #3;
        chk("rst_out_valid", 32'(ov3), 0);
        chk("rst_in_ready", 32'(ir3), 1);
        chk("rst_stage_en3", 32'(en3), 32'h7);
        chk("rst_stage_en4", 32'(en4), 32'hF);
        chk("rst_occupancy", 32'(oc3), 0);
        tick();
        rst = 0;
        check_en = 1;

        // Streaming words 1..10 with out_ready held high.
        out_ready = 1;
        for (int w = 1; w <= 10; w++) begin
            in_valid = 1; in_data = 8'(w);
            #1 chk("stream_in_ready", 32'(ir3), 1);
            tick();
            if (w < 3) begin
                chk("stream_latency", 32'(ov3), 0);
            end else begin
                chk("stream_latency", 32'(ov3), 1);
                chk("stream_word", 32'(dp3[2]), 32'(w - 2));
                chk("stream_occ", 32'(oc3), 3);
            end
        end
        in_valid = 0;
        repeat (5) tick();

        // Fill and stall: 5 offers, 3 accepted by the DEPTH=3 instance.
        out_ready = 0; in_data = 11; acc = 0;
        for (int o = 1; o <= 5; o++) begin
            in_valid = 1;
            #1;
            if (o >= 4) chk("fill_in_ready", 32'(ir3), 0);
            took = ir3;
            tick();
            if (took) begin
                acc++;
                in_data = in_data + 8'd1;
            end
        end
        chk("fill_accepted", 32'(acc), 3);
        chk("fill_occ", 32'(oc3), 3);
        chk("fill_stage_en", 32'(en3), 0);
        out_ready = 1;
        #1;
        chk("unstall_stage_en", 32'(en3), 32'h7);
        chk("unstall_in_ready", 32'(ir3), 1);
        tick();
        chk("unstall_occ", 32'(oc3), 3);
        in_valid = 0;
        repeat (6) tick();

        // Bubble collapse on the DEPTH=4 instance.
        in_valid = 1; in_data = 21; tick();
        in_valid = 0; tick(); tick();
        in_valid = 1; in_data = 22; tick();
        in_valid = 0; out_ready = 0;
        repeat (4) tick();
        chk("bubble_valid", 32'(sv4), 32'hC);
        chk("bubble_occ", 32'(oc4), 2);
        chk("bubble_in_ready", 32'(ir4), 1);
        chk("bubble_stage_en", 32'(en4), 32'h3);
        out_ready = 1;
        repeat (6) tick();

        // Flush with two words in flight and in_valid asserted.
        out_ready = 0;
        in_valid = 1; in_data = 31; tick();
        in_data = 32; tick();
        chk("flush_pre_occ", 32'(oc3), 2);
        flush = 1; in_data = 33;
        #1;
        chk("flush_in_ready", 32'(ir3), 0);
        chk("flush_stage_en", 32'(en3), 0);
        tick();
        flush = 0; in_valid = 0;
        chk("flush_valid", 32'(sv3), 0);
        chk("flush_occ", 32'(oc3), 0);
        repeat (3) begin
            tick();
            chk("flush_no_out", 32'(ov3), 0);
        end

        // Asynchronous reset between edges with the pipe full.
        in_valid = 1;
        for (int w = 41; w <= 43; w++) begin
            in_data = 8'(w);
            tick();
        end
        chk("arst_pre_occ", 32'(oc3), 3);
        #1 rst = 1;
        #1;
        chk("arst_out_valid", 32'(ov3), 0);
        chk("arst_in_ready", 32'(ir3), 1);
        chk("arst_stage_en3", 32'(en3), 32'h7);
        chk("arst_stage_en4", 32'(en4), 32'hF);
        chk("arst_occ", 32'(oc3), 0);
        chk("arst_valid", 32'(sv3), 0);
        #1 rst = 0;
        in_valid = 0;
        out_ready = 1;
        for (int w = 51; w <= 53; w++) begin
            in_valid = 1; in_data = 8'(w);
            tick();
        end
        in_valid = 0;
        repeat (5) tick();

`ifdef SVNET_PIPE_CTRL_PERF_EN
        // Performance counters on the DEPTH=2 instance.
        #1 rst = 1;
        #1 rst = 0;
        out_ready = 0;
        in_valid = 1; in_data = 61; tick();
        in_data = 62; tick();
        in_valid = 0;
        chk("perf_out_valid", 32'(ov2), 1);
        chk("perf_bubble", bc2, 1);
        repeat (7) tick();
        chk("perf_stall7", st2, 7);
        force u2.r_stall_cnt = 32'hFFFF_FFFE;
        #1 release u2.r_stall_cnt;
        repeat (3) tick();
        chk("perf_stall_sat", st2, 32'hFFFF_FFFF);
        out_ready = 1;
        repeat (4) tick();
`endif

        check_en = 0;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svnet_pipe_ctrl.md
Name: svnet_pipe_ctrl

Overview:
- Valid/ready sequencer for a chain of enable-gated pipeline registers.
- Drives the per-stage `enable` of DEPTH register stages in a CNN datapath, such as a MAC or pooling pipeline, and tracks which stages hold valid data.
- Collapses bubbles and propagates downstream backpressure, so the datapath stalls only where needed.
- Sits between an upstream producer handshake and a downstream consumer handshake. The datapath registers themselves live outside this block.

Parameters:
- DEPTH, 4, number of pipeline stages sequenced; legal range 1..64, elaboration error otherwise.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- flush  input  1  synchronous clear of all in-flight valid bits.
- in_valid  input  1  upstream has a word for stage 0.
- in_ready  output  1  stage 0 accepts this cycle.
- out_valid  output  1  last stage holds a valid word.
- out_ready  input  1  downstream accepts the last-stage word.
- stage_en  output  DEPTH  per-stage register load enable; bit i drives stage i datapath register enable.
- stage_valid  output  DEPTH  per-stage valid flags (registered).
- occupancy  output  CNT_W  count of valid stages (registered).

Behaviour:
- State: v[DEPTH-1:0] valid flags and occ counter. No other state unless the optional feature is enabled.
- Reset (async, rst=1): v=0, occ=0. Consequently out_valid=0, stage_valid=0, occupancy=0, in_ready=1, and stage_en is all ones (all stages empty). All are held while rst=1.
- Enable chain, combinational, evaluated from output back to input:
  - en[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - en[i] = !v[i] | en[i+1] for i<DEPTH-1.
  - stage_en = en; in_ready = en[0].
- Bubble collapsing: an empty stage always loads, so a stall at stage k does not block upstream stages while an empty stage exists below the stalled point.
- Combinational path out_ready -> in_ready is intentional. Depth of the chain is DEPTH OR levels.
- Valid update on each clock edge, when en[i]:
  - v[0] <= in_valid.
  - v[i] <= v[i-1].
  - When !en[i], v[i] holds.
- Transfer definitions:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid = v[DEPTH-1].
  - Latency: a word accepted at edge t appears with out_valid at edge t+DEPTH-1 registered (DEPTH cycles total) if never stalled.
- Occupancy: occ <= occ + in_xfer - out_xfer, computed in CNT_W+1 bits. It must equal popcount(v) at all times; an assertion is required in the bench. It never exceeds DEPTH and never underflows.
- Full: all v=1 and out_ready=0 -> stage_en=0, in_ready=0. Nothing moves and data holds.
- Full with out_ready=1: all stages enabled; simultaneous in and out transfer keeps occ unchanged.
- Empty: out_valid=0, so out_ready is ignored. in_ready=1 regardless of out_ready.
- Flush (synchronous, priority over handshakes):
  - Same cycle: stage_en=0 and in_ready=0, so no transfer occurs.
  - Next edge: v=0, occ=0.
  - out_valid stays as registered during the flush cycle; the consumer must ignore it when flush is known.
- Reset mid-operation: all in-flight words are discarded immediately, with no partial output. After deassertion the block behaves as fresh.
- stage_en for stages holding data is a don't-care hazard-free gate. The datapath may clock-gate on it.

Optional Feature:
- Macro: SVNET_PIPE_CTRL_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits). It increments by 1 on each cycle with out_valid=1 & out_ready=0 & flush=0, and saturates at 32'hFFFF_FFFF.
  - Adds output bubble_cnt (32 bits). It increments on each cycle with occ!=0 & out_valid=0, and saturates.
  - Both counters are cleared by rst only; flush does not clear them.
- Not defined: neither port exists and no counter logic is generated. Core behaviour is identical in both builds.

Test Plan:
- Streaming, DEPTH=3: in_valid=1 and out_ready=1 held for 10 cycles, words 1..10 -> first out_valid 3 cycles after the first acceptance, words 1..10 emerge in order, occupancy settles at 3, in_ready=1 throughout.
- Fill and stall, DEPTH=3: out_ready=0, 5 words offered -> exactly 3 accepted, in_ready=0 from the 4th offer, occupancy=3, stage_en=3'b000. Then out_ready=1 for one cycle -> one output transfer and one input transfer, occupancy stays 3.
- Bubble collapse, DEPTH=4: accept words A and B with a 2-cycle gap between them, then out_ready=0 -> after settling, v=4'b1100 packed toward the output, occupancy=2, in_ready=1.
- Flush, DEPTH=3, occupancy=2: assert flush for 1 cycle with in_valid=1 -> in_ready=0 in that cycle, next cycle v=0 and occupancy=0, no spurious out_valid afterwards.
- Async reset mid-stream: pulse rst between clock edges with occupancy=3 -> outputs go to reset values before the next edge, in_ready=1, stage_en=all ones.
- With SVNET_PIPE_CTRL_PERF_EN defined, DEPTH=2: fill, hold out_ready=0 for 7 cycles -> stall_cnt=7. Force stall_cnt to 32'hFFFF_FFFE, stall 3 more cycles -> stall_cnt=32'hFFFF_FFFF.
